// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Lets the IF stage (instruction fetch) and the MEM stage (lw/sw) share one
//   single-ported, variable-latency memory. Only one memory transaction is in
//   flight at a time.
//
//   Arbitration: the data side normally wins. A starvation counter makes sure
//   a pending fetch is not passed over by more than STARVE_LIMIT data grants.
//
//   Handshake semantics (all requesters):
//     x_req is held high until x_valid. A grant is only made from IDLE. The
//     address, write enable and write data are captured on the grant edge;
//     later changes on the request side have no effect on that transaction.
//     mem_req stays high until the cycle in which mem_ready is seen. mem_ready
//     may already be high in the first mem_req cycle. x_valid is a one-cycle
//     registered pulse on the cycle after the mem_ready cycle.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   if_req / if_addr           fetch request and PC
//   if_flush                   branch taken: discard the in-flight fetch result
//   if_rdata / if_valid        fetched instruction and its one-cycle pulse
//   if_stall                   fetch pending, result not yet returned
//   d_req / d_we / d_addr /
//   d_wdata                    data request (load when d_we=0, store when 1)
//   d_rdata / d_valid          load data and the completion pulse
//   d_stall                    data access pending, not yet done
//   mem_req / mem_we /
//   mem_addr / mem_wdata       registered memory request
//   mem_rdata / mem_ready      memory read data and completion
//   state_dbg                  current FSM state (0 idle, 1 busy fetch,
//                              2 busy data)
//   starve_dbg                 current starvation count
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   localparam int STARVE_W    = $clog2(STARVE_LIMIT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              d_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [1:0]        state_dbg,
   output logic [STARVE_W-1:0] starve_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_next;
   logic                if_valid_q;
   logic                d_valid_q;
   logic                drop_q;
   logic [STARVE_W-1:0] starve_q;

   logic req_eff_if;
   logic req_eff_d;
   logic grant_if;
   logic grant_d;
   logic starve_below;

   // A requester that is being answered this cycle must not be granted again
   // on the strength of the same (still high) request. A flush in IDLE also
   // keeps the old fetch address from being issued.
   assign req_eff_if   = if_req & ~if_valid_q & ~if_flush;
   assign req_eff_d    = d_req & ~d_valid_q;
   assign starve_below = (starve_q < STARVE_W'(STARVE_LIMIT));

   always_comb begin
      state_next = state_q;
      grant_if   = 1'b0;
      grant_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_eff_d && (!req_eff_if || starve_below)) begin
               grant_d    = 1'b1;
               state_next = BUSY_D;
            end else if (req_eff_if) begin
               grant_if   = 1'b1;
               state_next = BUSY_IF;
            end
         end
         BUSY_IF: begin
            if (mem_ready) state_next = IDLE;
         end
         BUSY_D: begin
            if (mem_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_next;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;

         if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
         end else if (grant_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
         end

         if (state_q == BUSY_IF) begin
            if (mem_ready) begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               drop_q  <= 1'b0;
               // A flush arriving in the completion cycle counts as a drop too.
               if (!(drop_q || if_flush)) begin
                  if_valid_q <= 1'b1;
                  if_rdata   <= mem_rdata;
               end
            end else if (if_flush) begin
               drop_q <= 1'b1;
            end
         end

         if (state_q == BUSY_D && mem_ready) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            d_valid_q <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
         end
      end
   end

   // Counts data grants that overtook a waiting fetch; saturates at the limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q <= '0;
      end else if (!if_req || grant_if) begin
         starve_q <= '0;
      end else if (grant_d && starve_below) begin
         starve_q <= starve_q + STARVE_W'(1);
      end
   end

   assign if_valid   = if_valid_q & ~if_flush;
   assign d_valid    = d_valid_q;
   assign if_stall   = if_req & ~if_valid;
   assign d_stall    = d_req & ~d_valid_q;
   assign state_dbg  = state_q;
   assign starve_dbg = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [1:0]  state_dbg;
  logic [2:0]  starve_dbg;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .state_dbg(state_dbg), .starve_dbg(starve_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus knobs ----------------
  bit          manual     = 1'b1;
  bit          force_rst  = 1'b1;
  int          p_rst      = 0;   // per mille
  int          p_if       = 0;   // percent
  int          p_d        = 0;
  int          p_store    = 0;
  int          p_flush    = 0;
  int          p_wd       = 0;
  int          dly_min    = 0;
  int          dly_max    = 0;
  int          rdata_mode = 0;   // 0 random, 1 constant, 2 address-tagged
  logic [31:0] rdata_fix  = '0;

  // memory responder state
  bit mem_busy = 1'b0;
  int mem_cnt  = 0;

  // observations from the last sampling point
  bit saw_if_valid = 1'b0;
  bit saw_d_valid  = 1'b0;
  bit sat_seen     = 1'b0;

  // ---------------- reference model (transaction level) ----------------
  bit          m_active;      // a memory transaction is outstanding
  bit          m_is_d;        // outstanding transaction belongs to the data side
  bit          m_we;
  bit          m_dropped;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          m_starve;      // data grants that overtook a waiting fetch
  bit          m_if_done;     // fetch result is announced this cycle
  bit          m_d_done;
  logic [31:0] m_if_rdata;
  logic [31:0] m_d_rdata;
  logic [31:0] exp_q[$];      // fetch results still to be announced

  task automatic model_reset();
    m_active   = 1'b0;
    m_is_d     = 1'b0;
    m_we       = 1'b0;
    m_dropped  = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_starve   = 0;
    m_if_done  = 1'b0;
    m_d_done   = 1'b0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
    exp_q.delete();
  endtask

  // Advances the model by one clock using the inputs held during this cycle.
  task automatic model_step();
    bit want_if, want_d, n_if, n_d;
    if (reset) begin
      model_reset();
      return;
    end
    n_if    = 1'b0;
    n_d     = 1'b0;
    want_if = if_req && !m_if_done && !if_flush;
    want_d  = d_req && !m_d_done;
    if (m_active) begin
      if (mem_ready) begin
        if (m_is_d) begin
          n_d = 1'b1;
          if (!m_we) m_d_rdata = mem_rdata;
        end else if (!(m_dropped || if_flush)) begin
          n_if = 1'b1;
          m_if_rdata = mem_rdata;
          exp_q.push_back(mem_rdata);
        end
        m_active  = 1'b0;
        m_dropped = 1'b0;
      end else if (!m_is_d && if_flush) begin
        m_dropped = 1'b1;
      end
    end else if (want_d && (!want_if || m_starve < LIMIT)) begin
      m_active = 1'b1; m_is_d = 1'b1; m_we = d_we;
      m_addr = d_addr; m_wdata = d_wdata;
      if (if_req && m_starve < LIMIT) m_starve++;
    end else if (want_if) begin
      m_active = 1'b1; m_is_d = 1'b0; m_we = 1'b0;
      m_addr = if_addr;
      m_starve = 0;
    end
    if (!if_req) m_starve = 0;
    m_if_done = n_if;
    m_d_done  = n_d;
  endtask

  task automatic check_outputs();
    logic       exp_ifv;
    logic [1:0] exp_state;
    logic [31:0] e;
    exp_ifv   = m_if_done & ~if_flush;
    exp_state = !m_active ? 2'd0 : (m_is_d ? 2'd2 : 2'd1);
    check("mem_req", mem_req, m_active);
    check("mem_we", mem_we, m_active & m_we);
    if (m_active) check("mem_addr", mem_addr, m_addr);
    if (m_active && m_we) check("mem_wdata", mem_wdata, m_wdata);
    check("if_valid", if_valid, exp_ifv);
    check("d_valid", d_valid, m_d_done);
    check("if_rdata", if_rdata, m_if_rdata);
    check("d_rdata", d_rdata, m_d_rdata);
    check("if_stall", if_stall, if_req & ~exp_ifv);
    check("d_stall", d_stall, d_req & ~m_d_done);
    check("state", state_dbg, exp_state);
    check("starve", starve_dbg, m_starve);
    if (m_if_done) begin
      e = exp_q.pop_front();
      if (!if_flush) check("if_txn", if_rdata, e);
    end
  endtask

  // ---------------- drivers ----------------
  function automatic logic [31:0] new_if_addr();
    return {16'h0001, 14'($urandom), 2'b00};
  endfunction

  function automatic logic [31:0] new_d_addr();
    return {16'h0008, 14'($urandom), 2'b00};
  endfunction

  task automatic drive_inputs();
    // memory responder: reacts to the request it sees after the edge
    if (reset) mem_busy = 1'b0;
    else if (mem_busy && mem_ready) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (mem_req === 1'b1 && !mem_busy) begin
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(dly_max, dly_min);
    end
    mem_ready = mem_busy && (mem_cnt == 0);
    case (rdata_mode)
      1:       mem_rdata = rdata_fix;
      2:       mem_rdata = {16'hCAFE, mem_addr[15:0]};
      default: mem_rdata = $urandom;
    endcase

    reset = force_rst || ($urandom_range(0, 999) < p_rst);

    if (!manual) begin
      if_flush = 1'b0;
      if (saw_if_valid) if_req = 1'b0;
      if (!if_req) begin
        if ($urandom_range(0, 99) < p_if) begin
          if_req  = 1'b1;
          if_addr = new_if_addr();
        end
      end else if ($urandom_range(0, 99) < p_flush) begin
        if_flush = 1'b1;
        if_addr  = new_if_addr();
      end

      if (saw_d_valid) d_req = 1'b0;
      if (!d_req) begin
        if ($urandom_range(0, 99) < p_d) begin
          d_req   = 1'b1;
          d_we    = ($urandom_range(0, 99) < p_store);
          d_addr  = new_d_addr();
          d_wdata = $urandom;
        end
      end else if ($urandom_range(0, 99) < p_wd) begin
        d_req = 1'b0;
      end
    end
  endtask

  // One clock: drive after the edge, check on the falling edge, then advance.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_inputs();
      @(negedge clk);
      check_outputs();
      saw_if_valid = (if_valid === 1'b1);
      saw_d_valid  = (d_valid === 1'b1);
      if (starve_dbg == 3'(LIMIT)) sat_seen = 1'b1;
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_idle_inputs();
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  // ---------------- test sequence ----------------
  int if_at, d_at, if_cnt, d_cnt;

  initial begin
    set_idle_inputs();
    reset     = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_d_valid", d_valid, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    check("rst_starve", starve_dbg, 3'd0);
    force_rst = 1'b0;
    run_cycles(2);

    // T1: plain fetch, memory answers 2 cycles after mem_req
    dly_min = 2; dly_max = 2; rdata_mode = 1; rdata_fix = 32'h00500093;
    if_req = 1'b1; if_addr = 32'h100;
    if_at = -1;
    for (int i = 0; i < 10; i++) begin
      run_cycles(1);
      if (saw_if_valid && if_at < 0) begin if_at = i; if_req = 1'b0; end
    end
    check("t1_latency", if_at, 4);
    check("t1_rdata", if_rdata, 32'h00500093);

    // T2: fetch and load in the same cycle, immediate ready
    dly_min = 0; dly_max = 0; rdata_fix = 32'h12345678;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    if_at = -1; d_at = -1;
    for (int i = 0; i < 10; i++) begin
      run_cycles(1);
      if (saw_d_valid && d_at < 0) begin d_at = i; d_req = 1'b0; end
      if (saw_if_valid && if_at < 0) begin if_at = i; if_req = 1'b0; end
    end
    check("t2_d_at", d_at, 2);
    check("t2_if_at", if_at, 4);
    check("t2_d_rdata", d_rdata, 32'h12345678);

    // T4: store leaves d_rdata alone even though mem_rdata is random
    dly_min = 1; dly_max = 1; rdata_mode = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEADBEEF;
    d_at = -1;
    for (int i = 0; i < 8; i++) begin
      run_cycles(1);
      if (saw_d_valid && d_at < 0) begin d_at = i; d_req = 1'b0; d_we = 1'b0; end
    end
    check("t4_d_at", d_at, 3);
    check("t4_d_rdata", d_rdata, 32'h12345678);

    // T5: flush while the fetch is outstanding, then fetch the branch target
    dly_min = 3; dly_max = 3; rdata_mode = 2;
    if_req = 1'b1; if_addr = 32'h300;
    if_at = -1; if_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin if_flush = 1'b1; if_addr = 32'h200; end
      if (i == 3) if_flush = 1'b0;
      run_cycles(1);
      if (saw_if_valid) begin
        if_cnt++;
        if (if_at < 0) if_at = i;
        if_req = 1'b0;
      end
    end
    check("t5_valid_count", if_cnt, 1);
    check("t5_if_at", if_at, 10);
    check("t5_rdata", if_rdata, 32'hCAFE0200);

    // T6: reset while a load is outstanding
    rdata_mode = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    if_req = 1'b1; if_addr = 32'h108;
    run_cycles(2);
    check("t6_starve_pre", starve_dbg, 3'd1);
    check("t6_busy_pre", mem_req, 1'b1);
    force_rst = 1'b1;
    run_cycles(1);
    force_rst = 1'b0;
    check("t6_mem_req", mem_req, 1'b0);
    check("t6_state", state_dbg, 2'd0);
    check("t6_starve", starve_dbg, 3'd0);
    check("t6_d_valid", d_valid, 1'b0);
    d_req = 1'b0; if_req = 1'b0;
    d_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycles(1);
      if (saw_d_valid) d_cnt++;
    end
    check("t6_no_valid", d_cnt, 0);

    // T3: both sides always requesting, frequent flushes let data grants pile up
    manual = 1'b0;
    p_if = 100; p_d = 100; p_store = 0; p_flush = 80; p_wd = 0;
    dly_min = 0; dly_max = 1;
    run_cycles(400);
    check("t3_starve_saturated", sat_seen, 1'b1);

    // random traffic with varied latency, stores, flushes, withdrawals, resets
    p_if = 60; p_d = 60; p_store = 40; p_flush = 10; p_wd = 5; p_rst = 5;
    dly_min = 0; dly_max = 4;
    run_cycles(3000);
    p_if = 100; p_d = 100; p_store = 50; p_flush = 30; p_wd = 0; p_rst = 2;
    dly_min = 0; dly_max = 2;
    run_cycles(3000);
    p_if = 30; p_d = 90; p_store = 20; p_flush = 5; p_wd = 10; p_rst = 0;
    dly_min = 1; dly_max = 6;
    run_cycles(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
